map_step_sequencer: RTL and testbench
=====================================

Name: map_step_sequencer

Overview:
- Controller that sequences the 8-bit nonlinear "spiking" map iterator for the sample-flow datapath.
- Decides when the map advances: single step, N-step burst, or free-run, with a programmable tick divider.
- Presents each new sample on a valid/ready stream and counts spike (wrap) events.
- Sits between the config/input pins and the sample consumer, e.g. display or GPIO serializer.

Parameters:
- DW, 8, map state / sample width (signed).
- DIV_W, 24, tick divider width.
- BURST_W, 8, burst length width.
- SPIKE_W, 16, spike counter width.
- THRESH, 50, signed spike threshold.
- RESET_VAL, -20, signed post-spike state.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a run (ignored while busy)
- stop  in  1  pulse; aborts a run
- clear_state  in  1  pulse; zeroes map state and spike_count (IDLE only)
- cfg_mode  in  2  0=none, 1=single, 2=burst, 3=free-run
- cfg_drive  in  8  unsigned drive input to map
- cfg_div  in  DIV_W  wait cycles between steps
- cfg_burst_len  in  BURST_W  steps per burst (0 treated as 1)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at natural end of single/burst
- out_valid  out  1  sample available
- out_ready  in  1  consumer accepts
- out_sample  out  DW  signed map state after step
- out_spike  out  1  sample produced by spike wrap
- spike_count  out  SPIKE_W  saturating spike count

Behaviour:
- Reset (clk edge with reset=1): FSM=IDLE, map state=0, spike_count=0, remaining=0, all outputs 0.
- Map step, done only when step_en=1:
  - If A >= THRESH (signed compare): A_next = RESET_VAL, spike=1.
  - Else: A_next = A + (drive>>2) + (A>>>3)*(A>>>3), with >>> an arithmetic (floor) shift. Result truncated mod 2^DW.
- Config latching: mode, drive, div and burst_len are captured on the accepted start edge and are stable for the whole run.
- start with cfg_mode=0 is ignored.
- FSM IDLE→WAIT on start while not busy.
  - WAIT loads cnt=cfg_div on entry and decrements each cycle.
  - When cnt==0, step_en=1 that cycle, then →EMIT.
  - Latency: start sampled at edge t → step at cycle t+1+div → out_valid high from cycle t+2+div.
- EMIT: out_valid=1; out_sample and out_spike are held stable until out_ready.
  - No further steps and no divider count while stalled.
  - On handshake: single, or burst with remaining==1 → done pulse next cycle, →IDLE.
  - Otherwise decrement remaining and →WAIT. Free-run always →WAIT.
- busy=1 in WAIT and EMIT.
- out_spike and spike_count update with the step. spike_count saturates at all-ones.
- stop:
  - In WAIT: →IDLE next cycle, no step, no done.
  - In EMIT: the pending sample completes its handshake (valid never drops), then →IDLE, no done.
  - stop and start in the same cycle while IDLE: start wins.
- clear_state: honoured only in IDLE (map state=0, spike_count=0); ignored while busy.
- Map state persists across runs unless cleared.
- reset mid-run: immediate return to reset values, out_valid drops.

Decomposition:
- Shared package map_pkg holds:
  - mode enum (MODE_NONE, MODE_SINGLE, MODE_BURST, MODE_FREE);
  - FSM state enum;
  - THRESH/RESET_VAL defaults.
- One sub-module, map_core: holds the state register. Inputs step_en, clear, drive; outputs state and spike.
- The sequencer owns the FSM, divider, burst counter and spike counter.

Test Plan:
- Single step: reset, clear, mode=1, drive=40, div=0, out_ready=1, start → out_valid at cycle t+2, sample=10, out_spike=0, done pulse, busy low after.
- Burst from 0: mode=2, len=5, drive=40, div=2, out_ready=1 → samples 10, 21, 35, 61, -20.
  - First valid at t+4, then one every 4 cycles.
  - out_spike only on the 5th sample; spike_count=1; single done pulse.
- Backpressure: burst run with out_ready low 5 cycles at the 2nd sample → out_sample stays 21 and out_valid stays high. No step occurs; the next sample is still 35.
- Free-run stop: mode=3, drive=40, div=0 → continuous samples. Assert stop while in WAIT → IDLE, no done.
  - Assert stop during a stalled EMIT → valid held until ready, then IDLE.
- Spike saturation and clear: SPIKE_W=2, long free-run → spike_count stops at 3.
  - clear_state while busy has no effect; in IDLE it zeroes spike_count and state (next single step → 10).
- Reset mid-burst: reset at the 3rd WAIT → busy=0, out_valid=0, state=0 next cycle. start ignored in the reset cycle.

Source files
------------

// File: rtl/map_pkg.sv
// ---------------------------------------------------------------------------
// map_pkg
// Shared types and defaults for the spiking-map step sequencer.
//   mode_e      : run mode selected on the cfg_mode pins
//   seq_state_e : sequencer FSM states
//   DEF_THRESH / DEF_RESET_VAL : default map spike threshold and post-spike
//                                state (both signed)
//   DRIVE_W     : width of the unsigned drive input to the map
// ---------------------------------------------------------------------------
package map_pkg;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_FREE   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } seq_state_e;

  localparam int DEF_THRESH    = 50;
  localparam int DEF_RESET_VAL = -20;
  localparam int DRIVE_W       = 8;

endpackage

// File: rtl/map_core.sv
// ---------------------------------------------------------------------------
// map_core
// Holds the 8-bit (DW) signed state of the nonlinear "spiking" map and
// advances it by one iteration whenever step_en is high:
//   A >= THRESH : A_next = RESET_VAL, spike
//   otherwise   : A_next = A + (drive >> 2) + (A >>> 3)^2   (mod 2^DW)
// Ports:
//   clk, reset  : clock, synchronous active-high reset (state -> 0)
//   step_en     : advance the map this cycle
//   clear       : zero the state and spike flag (only used while idle)
//   drive       : unsigned drive input
//   state       : current map state (registered)
//   spike       : 1 when the most recent step was a spike wrap (registered)
//   spike_evt   : combinational, high in the cycle a spiking step is taken
// ---------------------------------------------------------------------------
module map_core #(
  parameter int DW        = 8,
  parameter int DRIVE_W   = 8,
  parameter int THRESH    = 50,
  parameter int RESET_VAL = -20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_en,
  input  logic                 clear,
  input  logic [DRIVE_W-1:0]   drive,
  output logic signed [DW-1:0] state,
  output logic                 spike,
  output logic                 spike_evt
);

  localparam logic signed [DW-1:0] THRESH_C = DW'(THRESH);
  localparam logic signed [DW-1:0] RESET_C  = DW'(RESET_VAL);

  logic signed [DW-1:0] state_r;
  logic                 spike_r;
  logic signed [DW-1:0] quot_s;
  logic signed [DW-1:0] square_s;
  logic signed [DW-1:0] drive_term_s;
  logic signed [DW-1:0] next_s;
  logic                 at_thresh_s;

  // The result is truncated mod 2^DW, so every term can be formed directly
  // in DW bits: the low DW bits of a product or sum do not depend on the
  // discarded upper bits.
  assign quot_s       = state_r >>> 3'd3;
  assign square_s     = quot_s * quot_s;
  assign drive_term_s = DW'(drive >> 2'd2);
  assign at_thresh_s  = (state_r >= THRESH_C);

  // Next map state: spike wrap or nonlinear accumulate.
  always_comb begin
    next_s = state_r;
    if (at_thresh_s) begin
      next_s = RESET_C;
    end else begin
      next_s = state_r + drive_term_s + square_s;
    end
  end

  // Map state and spike flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= '0;
      spike_r <= 1'b0;
    end else if (clear) begin
      state_r <= '0;
      spike_r <= 1'b0;
    end else if (step_en) begin
      state_r <= next_s;
      spike_r <= at_thresh_s;
    end else begin
      state_r <= state_r;
      spike_r <= spike_r;
    end
  end

  assign state     = state_r;
  assign spike     = spike_r;
  assign spike_evt = step_en & at_thresh_s;

endmodule

// File: rtl/map_step_sequencer.sv
// ---------------------------------------------------------------------------
// map_step_sequencer
// Decides when the spiking map advances (single step, N-step burst or
// free-run, each step separated by cfg_div idle cycles) and presents every
// new map state on a valid/ready stream. Counts spike events (saturating).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : pulse, begins a run (ignored while busy or cfg_mode=0)
//   stop          : pulse, aborts a run (a pending sample still completes)
//   clear_state   : pulse, zeroes map state and spike_count (idle only)
//   cfg_mode      : 0 none, 1 single, 2 burst, 3 free-run
//   cfg_drive     : unsigned map drive
//   cfg_div       : wait cycles before each step
//   cfg_burst_len : steps per burst (0 behaves as 1)
//   busy          : run in progress
//   done          : one-cycle pulse at the natural end of single/burst
//   out_valid / out_ready : sample stream handshake
//   out_sample    : signed map state after the step
//   out_spike     : sample was produced by a spike wrap
//   spike_count   : saturating spike count
// All cfg_* inputs are captured when start is accepted.
// ---------------------------------------------------------------------------
module map_step_sequencer #(
  parameter int DW        = 8,
  parameter int DIV_W     = 24,
  parameter int BURST_W   = 8,
  parameter int SPIKE_W   = 16,
  parameter int THRESH    = map_pkg::DEF_THRESH,
  parameter int RESET_VAL = map_pkg::DEF_RESET_VAL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear_state,
  input  logic [1:0]           cfg_mode,
  input  logic [7:0]           cfg_drive,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [BURST_W-1:0]   cfg_burst_len,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_sample,
  output logic                 out_spike,
  output logic [SPIKE_W-1:0]   spike_count
);

  import map_pkg::*;

  seq_state_e           state_r;
  seq_state_e           state_next_s;
  mode_e                mode_r;
  logic [DRIVE_W-1:0]   drive_r;
  logic [DIV_W-1:0]     div_r;
  logic [DIV_W-1:0]     cnt_r;
  logic [BURST_W-1:0]   remaining_r;
  logic                 stop_pend_r;
  logic [SPIKE_W-1:0]   spike_cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 valid_r;

  logic                 start_ok_s;
  logic                 last_s;
  logic                 stop_seen_s;
  logic                 step_en_s;
  logic                 clear_en_s;
  logic                 done_next_s;
  logic                 busy_next_s;
  logic                 valid_next_s;
  logic signed [DW-1:0] core_state_s;
  logic                 core_spike_s;
  logic                 spike_evt_s;

  assign start_ok_s  = start && (mode_e'(cfg_mode) != MODE_NONE);
  // This handshake ends the run naturally: single, or the final burst step.
  assign last_s      = (mode_r == MODE_SINGLE) ||
                       ((mode_r == MODE_BURST) && (remaining_r == BURST_W'(1)));
  // A stop seen earlier during a stalled EMIT still counts at the handshake.
  assign stop_seen_s = stop || stop_pend_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_next_s = ST_IDLE;
        end else if (cnt_r == '0) begin
          state_next_s = ST_EMIT;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (!out_ready) begin
          state_next_s = ST_EMIT;
        end else if (stop_seen_s || last_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: step strobe, clear qualifier and next values of the
  // registered status outputs.
  always_comb begin
    step_en_s    = 1'b0;
    clear_en_s   = 1'b0;
    done_next_s  = 1'b0;
    busy_next_s  = (state_next_s != ST_IDLE);
    valid_next_s = (state_next_s == ST_EMIT);
    case (state_r)
      ST_IDLE: begin
        clear_en_s = clear_state;
      end
      ST_WAIT: begin
        // A stop in the step cycle cancels the step.
        step_en_s = (cnt_r == '0) && !stop;
      end
      ST_EMIT: begin
        done_next_s = out_ready && last_s && !stop_seen_s;
      end
      default: begin
        step_en_s = 1'b0;
      end
    endcase
  end

  // Run configuration, divider, burst counter and deferred-stop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r      <= MODE_NONE;
      drive_r     <= '0;
      div_r       <= '0;
      cnt_r       <= '0;
      remaining_r <= '0;
      stop_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          stop_pend_r <= 1'b0;
          if (start_ok_s) begin
            mode_r  <= mode_e'(cfg_mode);
            drive_r <= cfg_drive;
            div_r   <= cfg_div;
            cnt_r   <= cfg_div;
            if ((mode_e'(cfg_mode) == MODE_BURST) && (cfg_burst_len != '0)) begin
              remaining_r <= cfg_burst_len;
            end else begin
              remaining_r <= BURST_W'(1);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_WAIT: begin
          stop_pend_r <= 1'b0;
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - DIV_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            stop_pend_r <= 1'b0;
            cnt_r       <= div_r;
            if ((mode_r == MODE_BURST) && (remaining_r != '0)) begin
              remaining_r <= remaining_r - BURST_W'(1);
            end else begin
              remaining_r <= remaining_r;
            end
          end else if (stop) begin
            stop_pend_r <= 1'b1;
          end else begin
            stop_pend_r <= stop_pend_r;
          end
        end
        default: begin
          stop_pend_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating spike counter, zeroed together with the map state.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_cnt_r <= '0;
    end else if (clear_en_s) begin
      spike_cnt_r <= '0;
    end else if (spike_evt_s && (spike_cnt_r != '1)) begin
      spike_cnt_r <= spike_cnt_r + SPIKE_W'(1);
    end else begin
      spike_cnt_r <= spike_cnt_r;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
      valid_r <= valid_next_s;
    end
  end

  map_core #(
    .DW        (DW),
    .DRIVE_W   (DRIVE_W),
    .THRESH    (THRESH),
    .RESET_VAL (RESET_VAL)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .step_en   (step_en_s),
    .clear     (clear_en_s),
    .drive     (drive_r),
    .state     (core_state_s),
    .spike     (core_spike_s),
    .spike_evt (spike_evt_s)
  );

  assign busy        = busy_r;
  assign done        = done_r;
  assign out_valid   = valid_r;
  assign out_sample  = core_state_s;
  assign out_spike   = core_spike_s;
  assign spike_count = spike_cnt_r;

endmodule

// File: tb/tb_map_step_sequencer.sv
// Directed bench for map_step_sequencer (SPIKE_W reduced to 2 so that
// saturation is reachable quickly).
module tb_map_step_sequencer;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic              clear_state;
  logic [1:0]        cfg_mode;
  logic [7:0]        cfg_drive;
  logic [23:0]       cfg_div;
  logic [7:0]        cfg_burst_len;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_sample;
  logic              out_spike;
  logic [1:0]        spike_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  map_step_sequencer #(
    .DW(8), .DIV_W(24), .BURST_W(8), .SPIKE_W(2), .THRESH(50), .RESET_VAL(-20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .clear_state   (clear_state),
    .cfg_mode      (cfg_mode),
    .cfg_drive     (cfg_drive),
    .cfg_div       (cfg_div),
    .cfg_burst_len (cfg_burst_len),
    .busy          (busy),
    .done          (done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sample    (out_sample),
    .out_spike     (out_spike),
    .spike_count   (spike_count)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        cl;
    logic [1:0]  mode;
    logic [23:0] div;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        valid;
    int          sample;
    logic        spike;
    int          count;
  } vec_t;

  vec_t vt[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int rst, input int st, input int cl,
                              input int mode, input int div, input int len,
                              input int e_busy, input int e_done, input int e_valid,
                              input int e_sample, input int e_spike, input int e_count);
    vec_t v;
    v.rst    = (rst != 0);
    v.st     = (st != 0);
    v.cl     = (cl != 0);
    v.mode   = 2'(mode);
    v.div    = 24'(div);
    v.len    = 8'(len);
    v.busy   = (e_busy != 0);
    v.done   = (e_done != 0);
    v.valid  = (e_valid != 0);
    v.sample = e_sample;
    v.spike  = (e_spike != 0);
    v.count  = e_count;
    vt.push_back(v);
  endfunction

  // Bounded wait for out_valid; an expired budget shows up as a failed check.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while ((out_valid !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    chk({name, " valid"}, int'(out_valid), 1);
  endtask

  task automatic pulse_clear();
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs[5];
    int fr[6];
    int prev;
    bs = '{10, 21, 35, 61, -20};
    fr = '{10, 21, 35, 61, -20, -1};

    reset = 1'b1; start = 1'b0; stop = 1'b0; clear_state = 1'b0;
    cfg_mode = 2'd0; cfg_drive = 8'd40; cfg_div = 24'd0; cfg_burst_len = 8'd0;
    out_ready = 1'b1;

    // ---- table: reset, single step, 5-step burst with div=2 ----
    //   rst st cl mode div len | busy done valid sample spike count
    add(1, 0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0,   0, 0, 0);
    add(0, 1, 0, 1, 0, 0,   1, 0, 0,   0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   1, 0, 1,  10, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 1, 0,  10, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 0, 0,  10, 0, 0);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0,   0, 0, 0);
    add(0, 1, 0, 2, 2, 5,   1, 0, 0,   0, 0, 0);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      add(0, 0, 0, 2, 2, 5, 1, 0, 0, prev, 0, 0);
      add(0, 0, 0, 2, 2, 5, 1, 0, 0, prev, 0, 0);
      add(0, 0, 0, 2, 2, 5, 1, 0, 1, bs[k], (k == 4) ? 1 : 0, (k == 4) ? 1 : 0);
      if (k < 4) add(0, 0, 0, 2, 2, 5, 1, 0, 0, bs[k], 0, 0);
      prev = bs[k];
    end
    add(0, 0, 0, 2, 2, 5,   0, 1, 0, -20, 1, 1);
    add(0, 0, 0, 2, 2, 5,   0, 0, 0, -20, 1, 1);
    add(0, 1, 0, 0, 0, 0,   0, 0, 0, -20, 1, 1);  // start with mode 0 ignored

    foreach (vt[i]) begin
      reset = vt[i].rst; start = vt[i].st; clear_state = vt[i].cl;
      cfg_mode = vt[i].mode; cfg_div = vt[i].div; cfg_burst_len = vt[i].len;
      tick();
      chk($sformatf("row%0d busy", i),   int'(busy),        int'(vt[i].busy));
      chk($sformatf("row%0d done", i),   int'(done),        int'(vt[i].done));
      chk($sformatf("row%0d valid", i),  int'(out_valid),   int'(vt[i].valid));
      chk($sformatf("row%0d sample", i), int'(out_sample),  vt[i].sample);
      chk($sformatf("row%0d spike", i),  int'(out_spike),   int'(vt[i].spike));
      chk($sformatf("row%0d count", i),  int'(spike_count), vt[i].count);
    end
    reset = 1'b0; start = 1'b0; clear_state = 1'b0;

    // ---- backpressure on the 2nd burst sample ----
    pulse_clear();
    cfg_mode = 2'd2; cfg_div = 24'd2; cfg_burst_len = 8'd5; out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid("bp1");
    chk("bp1 sample", int'(out_sample), 10);
    tick();
    out_ready = 1'b0;
    wait_valid("bp2");
    chk("bp2 sample", int'(out_sample), 21);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp stall valid", int'(out_valid), 1);
      chk("bp stall sample", int'(out_sample), 21);
    end
    out_ready = 1'b1;
    tick();
    wait_valid("bp3");
    chk("bp3 sample", int'(out_sample), 35);
    stop = 1'b1; tick(); stop = 1'b0;  // stop together with handshake
    chk("bp stop busy", int'(busy), 0);
    chk("bp stop done", int'(done), 0);

    // ---- free-run, then stop in WAIT ----
    pulse_clear();
    cfg_mode = 2'd3; cfg_div = 24'd0; out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_valid("fr");
      chk($sformatf("fr%0d sample", k), int'(out_sample), fr[k]);
      chk($sformatf("fr%0d spike", k), int'(out_spike), (k == 4) ? 1 : 0);
      tick();
    end
    chk("fr in wait", int'(busy), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("fr stop busy", int'(busy), 0);
    chk("fr stop valid", int'(out_valid), 0);
    chk("fr stop sample", int'(out_sample), -1);
    chk("fr stop count", int'(spike_count), 1);
    tick();
    chk("fr stop done", int'(done), 0);

    // ---- stop during a stalled EMIT ----
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid("se");
    chk("se sample", int'(out_sample), 10);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("se held valid", int'(out_valid), 1);
    chk("se held sample", int'(out_sample), 10);
    tick();
    chk("se held valid2", int'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("se end valid", int'(out_valid), 0);
    chk("se end busy", int'(busy), 0);
    chk("se end done", int'(done), 0);
    tick();
    chk("se end done2", int'(done), 0);

    // ---- spike saturation and clear ----
    pulse_clear();
    start = 1'b1; tick(); start = 1'b0;
    repeat (80) tick();
    chk("sat count", int'(spike_count), 3);
    clear_state = 1'b1; tick(); clear_state = 1'b0;
    chk("sat busy clear count", int'(spike_count), 3);
    chk("sat busy clear busy", int'(busy), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("sat stop busy", int'(busy), 0);
    pulse_clear();
    chk("idle clear count", int'(spike_count), 0);
    chk("idle clear sample", int'(out_sample), 0);
    cfg_mode = 2'd1;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid("post");
    chk("post sample", int'(out_sample), 10);
    tick();
    chk("post done", int'(done), 1);

    // ---- reset in the 3rd WAIT of a burst ----
    pulse_clear();
    cfg_mode = 2'd2; cfg_div = 24'd2; cfg_burst_len = 8'd5;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid("rs1"); tick();
    wait_valid("rs2"); tick();
    chk("rs wait busy", int'(busy), 1);
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    chk("rs busy", int'(busy), 0);
    chk("rs valid", int'(out_valid), 0);
    chk("rs sample", int'(out_sample), 0);
    chk("rs count", int'(spike_count), 0);
    tick();
    chk("rs start ignored", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
